// File: rtl/ram_mover_pkg.sv
// Shared types and default geometry for the RAM block mover and its RAM.
package ram_mover_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = ADDR_W_DEF + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    FILL,
    DONE
  } mover_state_e;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mover_mode_e;

endpackage

// File: rtl/ram_block_mover.sv
// RAM block mover: COPY (read/write per word) and FILL (one write per cycle)
// over a single-port RAM with 1-cycle registered read latency.
// Optional checksum output enabled by RAM_BLOCK_MOVER_CHKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start_i, RAM port quiet
// RD    | COPY: present source address
// WR    | COPY: write returned read data to destination
// FILL  | FILL: write masked constant to destination
// DONE  | one-cycle completion pulse, back to IDLE
module ram_block_mover
  import ram_mover_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [ADDR_W-1:0]   src_i,
  input  logic [ADDR_W-1:0]   dst_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [DATA_W-1:0]   fill_dat_i,
  input  logic [DATA_W/8-1:0] fill_be_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic [LEN_W-1:0]    words_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_adr_o,
  output logic [DATA_W/8-1:0] ram_be_o,
  output logic [DATA_W-1:0]   ram_dat_o,
  input  logic [DATA_W-1:0]   ram_rdata_i
`ifdef RAM_BLOCK_MOVER_CHKSUM_EN
  ,
  output logic [DATA_W-1:0]   chksum_o
`endif
);

  localparam int BE_W = DATA_W / 8;

  mover_state_e      state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  rem_q, words_q;
  logic [DATA_W-1:0] fill_dat_q;
  logic [BE_W-1:0]   fill_be_q;
  logic              aborted_q;

  logic accept;
  logic step;
  logic set_abort;

  // Next state and RAM port decode; only WR forwards ram_rdata_i combinationally.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    set_abort = 1'b0;
    ram_we_o  = 1'b0;
    ram_adr_o = '0;
    ram_be_o  = '0;
    ram_dat_o = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept = 1'b1;
          if (len_i == '0)
            state_d = DONE;
          else if (mover_mode_e'(mode_i) == MODE_FILL)
            state_d = FILL;
          else
            state_d = RD;
        end
      end
      RD: begin
        ram_adr_o = src_q;
        if (abort_i) begin
          set_abort = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        ram_adr_o = dst_q;
        ram_be_o  = '1;
        ram_dat_o = ram_rdata_i;
        if (abort_i) begin
          set_abort = 1'b1;
          state_d   = DONE;
        end else begin
          ram_we_o = 1'b1;
          step     = 1'b1;
          state_d  = (rem_q == LEN_W'(1)) ? DONE : RD;
        end
      end
      FILL: begin
        ram_adr_o = dst_q;
        ram_be_o  = fill_be_q;
        ram_dat_o = fill_dat_q;
        if (abort_i) begin
          set_abort = 1'b1;
          state_d   = DONE;
        end else begin
          ram_we_o = 1'b1;
          step     = 1'b1;
          state_d  = (rem_q == LEN_W'(1)) ? DONE : FILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Command capture and per-write address/count advance; addresses wrap naturally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      words_q    <= '0;
      fill_dat_q <= '0;
      fill_be_q  <= '0;
      aborted_q  <= 1'b0;
    end else if (accept) begin
      src_q      <= src_i;
      dst_q      <= dst_i;
      rem_q      <= len_i;
      words_q    <= '0;
      fill_dat_q <= fill_dat_i;
      fill_be_q  <= fill_be_i;
      aborted_q  <= 1'b0;
    end else begin
      if (step) begin
        dst_q   <= dst_q + ADDR_W'(1);
        rem_q   <= rem_q - LEN_W'(1);
        words_q <= words_q + LEN_W'(1);
        if (state_q == WR) src_q <= src_q + ADDR_W'(1);
      end
      if (set_abort) aborted_q <= 1'b1;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign aborted_o = done_o & aborted_q;
  assign words_o   = words_q;

`ifdef RAM_BLOCK_MOVER_CHKSUM_EN
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] chksum_q;

  // Expand byte enables so masked bytes contribute zero to the checksum.
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < BE_W; b++) wr_mask[b*8 +: 8] = {8{ram_be_o[b]}};
  end

  // XOR-accumulate every word actually written by the current command.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      chksum_q <= '0;
    else if (accept)   chksum_q <= '0;
    else if (ram_we_o) chksum_q <= chksum_q ^ (ram_dat_o & wr_mask);
  end

  assign chksum_o = chksum_q;
`endif

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: table vectors, hand-written corner sequences and
// random commands checked against an array-level reference model.
module tb_ram_block_mover;

  localparam int N = 8192;

  typedef struct {
    bit          mode;
    int          src;
    int          dst;
    int          len;
    logic [31:0] fdat;
    logic [3:0]  fbe;
    int          abort_cyc;
    int          extra_start;
    bit          abort_w_start;
    int          exp_words;
    bit          exp_abort;
    int          exp_cyc;
  } vec_t;

  logic        clk, rst_n;
  logic        start_i, mode_i, abort_i;
  logic [12:0] src_i, dst_i;
  logic [13:0] len_i;
  logic [31:0] fill_dat_i;
  logic [3:0]  fill_be_i;
  logic        busy_o, done_o, aborted_o;
  logic [13:0] words_o;
  logic        ram_we_o;
  logic [12:0] ram_adr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_dat_o, ram_rdata;
`ifdef RAM_BLOCK_MOVER_CHKSUM_EN
  logic [31:0] chksum_o;
`endif

  logic [31:0] mem     [0:N-1];
  logic [31:0] ref_mem [0:N-1];
  logic        mem_init, pre_we;
  logic [12:0] pre_adr;
  logic [31:0] pre_dat;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];

  ram_block_mover dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .src_i      (src_i),
    .dst_i      (dst_i),
    .len_i      (len_i),
    .fill_dat_i (fill_dat_i),
    .fill_be_i  (fill_be_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .aborted_o  (aborted_o),
    .words_o    (words_o),
    .ram_we_o   (ram_we_o),
    .ram_adr_o  (ram_adr_o),
    .ram_be_o   (ram_be_o),
    .ram_dat_o  (ram_dat_o),
    .ram_rdata_i(ram_rdata)
`ifdef RAM_BLOCK_MOVER_CHKSUM_EN
    ,
    .chksum_o   (chksum_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Single-port RAM responder: byte-enabled write, 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < N; i++) mem[i] <= pat(i);
    end else if (pre_we) begin
      mem[pre_adr] <= pre_dat;
    end else if (ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_be_o[b]) mem[ram_adr_o][b*8 +: 8] <= ram_dat_o[b*8 +: 8];
    end
    ram_rdata <= mem[ram_adr_o];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit mode, int src, int dst, int len, logic [31:0] fdat,
                              logic [3:0] fbe, int abort_cyc, int extra_start,
                              bit abort_w_start, int ew, bit ea, int ec);
    vec_t v;
    v.mode = mode; v.src = src; v.dst = dst; v.len = len; v.fdat = fdat; v.fbe = fbe;
    v.abort_cyc = abort_cyc; v.extra_start = extra_start; v.abort_w_start = abort_w_start;
    v.exp_words = ew; v.exp_abort = ea; v.exp_cyc = ec;
    return v;
  endfunction

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_adr = 13'(a); pre_dat = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Reference: apply the command word by word in ascending order on the array.
  task automatic model_cmd(input vec_t v, input int nw, output logic [31:0] csum);
    logic [31:0] m, w;
    int a;
    csum = '0;
    for (int i = 0; i < nw; i++) begin
      a = (v.dst + i) % N;
      if (!v.mode) begin
        w = ref_mem[(v.src + i) % N];
        ref_mem[a] = w;
        csum ^= w;
      end else begin
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{v.fbe[b]}};
        ref_mem[a] = (ref_mem[a] & ~m) | (v.fdat & m);
        csum ^= v.fdat & m;
      end
    end
  endtask

  task automatic mem_compare(input string nm);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic do_vec(input vec_t v, input string nm);
    int cyc, nwr, words;
    bit ab, addr_ok;
    logic [31:0] csum_exp, csum_dut;
    @(negedge clk);
    start_i = 1'b1; mode_i = v.mode; src_i = 13'(v.src); dst_i = 13'(v.dst);
    len_i = 14'(v.len); fill_dat_i = v.fdat; fill_be_i = v.fbe; abort_i = v.abort_w_start;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    cyc = -1; nwr = 0; addr_ok = 1'b1; words = 0; ab = 1'b0; csum_dut = '0;
    for (int c = 0; c < 20000; c++) begin
      abort_i = (c == v.abort_cyc);
      if (c == v.extra_start) begin
        start_i = 1'b1; mode_i = ~v.mode; len_i = 14'd5; dst_i = 13'(v.dst + 7);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      if (ram_we_o) begin
        if (int'(ram_adr_o) != (v.dst + nwr) % N) addr_ok = 1'b0;
        nwr++;
      end
      if (done_o) begin
        cyc = c; words = int'(words_o); ab = aborted_o;
`ifdef RAM_BLOCK_MOVER_CHKSUM_EN
        csum_dut = chksum_o;
`endif
        break;
      end
      @(posedge clk); #1;
    end
    abort_i = 1'b0; start_i = 1'b0;
    chk({nm, "_timeout"}, (cyc < 0), 0);
    chk({nm, "_done_cyc"}, cyc, v.exp_cyc);
    chk({nm, "_words"}, words, v.exp_words);
    chk({nm, "_aborted"}, ab, v.exp_abort);
    chk({nm, "_nwrites"}, nwr, v.exp_words);
    chk({nm, "_wr_addr"}, addr_ok, 1);
    @(posedge clk); @(negedge clk);
    chk({nm, "_post_idle"}, {busy_o, done_o}, 0);
    model_cmd(v, v.exp_words, csum_exp);
`ifdef RAM_BLOCK_MOVER_CHKSUM_EN
    chk({nm, "_chksum"}, csum_dut, csum_exp);
`endif
    mem_compare({nm, "_mem"});
  endtask

  initial begin
    logic [31:0] dummy;
    int dcount, wcount;
    rst_n = 1'b0; mem_init = 1'b1; pre_we = 1'b0; pre_adr = '0; pre_dat = '0;
    start_i = 0; mode_i = 0; abort_i = 0; src_i = '0; dst_i = '0; len_i = '0;
    fill_dat_i = '0; fill_be_i = '0;
    for (int i = 0; i < N; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out", {busy_o, done_o, aborted_o, ram_we_o, ram_be_o}, 0);
    chk("idle_words", words_o, 0);
    chk("idle_adr_dat", {ram_adr_o, ram_dat_o}, 0);

    preload(0, 32'd1); preload(1, 32'd2); preload(2, 32'd3);
    preload('h40, 32'hDEAD_0000); preload('h41, 32'h0000_1111);

    vecs[0] = mk(1, 0,      'h010, 4, 32'hA5A5_A5A5, 4'hF, -1, -1, 0, 4, 0, 4);
    vecs[1] = mk(0, 'h000,  'h100, 3, 0,             4'h0, -1, -1, 0, 3, 0, 6);
    vecs[2] = mk(0, 'h1FFE, 'h020, 4, 0,             4'h0, -1, -1, 0, 4, 0, 8);
    vecs[3] = mk(0, 'h040,  'h041, 2, 0,             4'h0, -1, -1, 0, 2, 0, 4);
    vecs[4] = mk(1, 0,      'h200, 8, 32'h1234_5678, 4'hF,  2,  1, 0, 2, 1, 3);
    vecs[5] = mk(1, 0,      'h300, 0, 32'hFFFF_FFFF, 4'hF, -1, -1, 0, 0, 0, 0);
    vecs[6] = mk(1, 0,      'h310, 2, 32'h0F0F_0F0F, 4'h3, -1, -1, 0, 2, 0, 2);
    vecs[7] = mk(1, 0,      'h1FFF, 3, 32'hCAFE_F00D, 4'hA, -1, -1, 1, 3, 0, 3);

    for (int t = 0; t < 8; t++) begin
      do_vec(vecs[t], $sformatf("vec%0d", t));
      if (t == 0) chk("fill_0x013", mem['h013], 32'hA5A5_A5A5);
      if (t == 1) chk("copy_0x102", mem['h102], 32'd3);
      if (t == 3) begin
        chk("overlap_0x41", mem['h41], 32'hDEAD_0000);
        chk("overlap_0x42", mem['h42], 32'hDEAD_0000);
      end
`ifdef RAM_BLOCK_MOVER_CHKSUM_EN
      if (t == 6) chk("chksum_cancel", chksum_o, 0);
`endif
    end

    // Reset mid-FILL: three writes land, then nothing more and no done pulse.
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b1; dst_i = 13'h400; len_i = 14'd10;
    fill_dat_i = 32'h1357_9BDF; fill_be_i = 4'hF;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_we", ram_we_o, 0);
    chk("midrst_words", words_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0; wcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o) dcount++;
      if (ram_we_o) wcount++;
    end
    chk("midrst_no_done", dcount, 0);
    chk("midrst_no_wr", wcount, 0);
    model_cmd(mk(1, 0, 'h400, 10, 32'h1357_9BDF, 4'hF, -1, -1, 0, 3, 0, 0), 3, dummy);
    mem_compare("midrst_mem");

    // Random commands against the array model.
    for (int r = 0; r < 40; r++) begin
      vec_t v;
      int total;
      v.mode = 1'($urandom_range(0, 1));
      v.src = int'($urandom_range(0, N - 1));
      v.dst = (r % 5 == 0) ? N - 2 : int'($urandom_range(0, N - 1));
      v.len = int'($urandom_range(0, 24));
      v.fdat = $urandom;
      v.fbe = 4'($urandom_range(0, 15));
      total = v.mode ? v.len : 2 * v.len;
      v.abort_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * v.len + 1)) : -1;
      v.extra_start = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      v.abort_w_start = 1'($urandom_range(0, 1));
      v.exp_abort = (v.abort_cyc >= 0) && (v.abort_cyc < total);
      v.exp_words = v.exp_abort ? (v.mode ? v.abort_cyc : v.abort_cyc / 2) : v.len;
      v.exp_cyc = v.exp_abort ? v.abort_cyc + 1 : total;
      do_vec(v, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
